// File: rtl/floo_test_pkg.sv
// Shared definitions for the AXI performance monitor.
//   perf_mon_state_e : global monitor FSM states
//   perf_axi_req_t / perf_axi_rsp_t : minimal default tap structs carrying only the
//     handshake fields the monitor looks at (floo naming of the AXI channel fields)
//   sat_add          : increment that sticks at the all-ones value of a given width
package floo_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } perf_mon_state_e;

    typedef struct packed {
        logic last;
    } perf_r_chan_t;

    typedef struct packed {
        logic aw_valid;
        logic w_valid;
        logic b_ready;
        logic ar_valid;
        logic r_ready;
    } perf_axi_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         w_ready;
        logic         b_valid;
        logic         ar_ready;
        logic         r_valid;
        perf_r_chan_t r;
    } perf_axi_rsp_t;

    // Adds inc to a, but never past the largest value representable in 'width' bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic inc,
                                            input int unsigned width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        if (!inc || (a >= max_v)) begin
            return a;
        end
        return a + 64'd1;
    endfunction

endpackage

// File: rtl/floo_axi_perf_port.sv
// Per-port statistics slice of the AXI performance monitor.
// Inputs : clk_i, rst_ni (async, active-low), clear_i (sync clear),
//          count_i (window is counting), snap_i (close window this cycle),
//          flush_i (discard partial window), decoded handshakes of the port.
// Outputs: r/w beat snapshots, ar/aw in-flight counts and peaks, sticky err_o.
module floo_axi_perf_port
    import floo_test_pkg::*;
#(
    parameter int unsigned CntWidth      = 32,
    parameter int unsigned InFlightWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     count_i,
    input  logic                     snap_i,
    input  logic                     flush_i,
    input  logic                     ar_hs_i,
    input  logic                     r_hs_i,
    input  logic                     r_last_hs_i,
    input  logic                     aw_hs_i,
    input  logic                     w_hs_i,
    input  logic                     b_hs_i,
    output logic [CntWidth-1:0]      r_beats_o,
    output logic [CntWidth-1:0]      w_beats_o,
    output logic [InFlightWidth-1:0] ar_in_flight_o,
    output logic [InFlightWidth-1:0] aw_in_flight_o,
    output logic [InFlightWidth-1:0] ar_peak_o,
    output logic [InFlightWidth-1:0] aw_peak_o,
    output logic                     err_o
);

    logic [InFlightWidth-1:0] ar_q, ar_d, aw_q, aw_d;
    logic [InFlightWidth-1:0] ar_peak_q, ar_peak_d, aw_peak_q, aw_peak_d;
    logic [CntWidth-1:0]      r_acc_q, r_acc_d, w_acc_q, w_acc_d;
    logic [CntWidth-1:0]      r_snap_q, r_snap_d, w_snap_q, w_snap_d;
    logic                     err_q, err_d;
    logic                     ar_err, aw_err;

    // Returns {error, next_count}. Simultaneous inc and dec cancel out; an
    // increment at all-ones or a decrement at zero holds the count and flags error.
    function automatic logic [InFlightWidth:0] step_cnt(input logic [InFlightWidth-1:0] cnt,
                                                       input logic inc, input logic dec);
        logic [InFlightWidth-1:0] nxt;
        logic                     err;
        nxt = cnt;
        err = 1'b0;
        if (inc && !dec) begin
            if (&cnt) err = 1'b1;
            else      nxt = cnt + InFlightWidth'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           nxt = cnt - InFlightWidth'(1);
        end
        return {err, nxt};
    endfunction

    always_comb begin
        {ar_err, ar_d} = step_cnt(ar_q, ar_hs_i, r_last_hs_i);
        {aw_err, aw_d} = step_cnt(aw_q, aw_hs_i, b_hs_i);
        // Peaks follow the registered counts, hence one cycle behind a new maximum.
        ar_peak_d = (ar_q > ar_peak_q) ? ar_q : ar_peak_q;
        aw_peak_d = (aw_q > aw_peak_q) ? aw_q : aw_peak_q;
        err_d     = err_q | ar_err | aw_err;
        r_acc_d   = r_acc_q;
        w_acc_d   = w_acc_q;
        r_snap_d  = r_snap_q;
        w_snap_d  = w_snap_q;
        if (snap_i) begin
            // The closing cycle's own beat belongs to the window being closed.
            r_snap_d = CntWidth'(sat_add(64'(r_acc_q), r_hs_i, CntWidth));
            w_snap_d = CntWidth'(sat_add(64'(w_acc_q), w_hs_i, CntWidth));
            r_acc_d  = '0;
            w_acc_d  = '0;
        end else if (flush_i) begin
            r_acc_d = '0;
            w_acc_d = '0;
        end else if (count_i) begin
            r_acc_d = CntWidth'(sat_add(64'(r_acc_q), r_hs_i, CntWidth));
            w_acc_d = CntWidth'(sat_add(64'(w_acc_q), w_hs_i, CntWidth));
        end
        if (clear_i) begin
            ar_d      = '0;
            aw_d      = '0;
            ar_peak_d = '0;
            aw_peak_d = '0;
            r_acc_d   = '0;
            w_acc_d   = '0;
            r_snap_d  = '0;
            w_snap_d  = '0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_q      <= '0;
            aw_q      <= '0;
            ar_peak_q <= '0;
            aw_peak_q <= '0;
            r_acc_q   <= '0;
            w_acc_q   <= '0;
            r_snap_q  <= '0;
            w_snap_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            ar_q      <= ar_d;
            aw_q      <= aw_d;
            ar_peak_q <= ar_peak_d;
            aw_peak_q <= aw_peak_d;
            r_acc_q   <= r_acc_d;
            w_acc_q   <= w_acc_d;
            r_snap_q  <= r_snap_d;
            w_snap_q  <= w_snap_d;
            err_q     <= err_d;
        end
    end

    assign r_beats_o      = r_snap_q;
    assign w_beats_o      = w_snap_q;
    assign ar_in_flight_o = ar_q;
    assign aw_in_flight_o = aw_q;
    assign ar_peak_o      = ar_peak_q;
    assign aw_peak_o      = aw_peak_q;
    assign err_o          = err_q;

endmodule

// File: rtl/floo_axi_perf_monitor.sv
// Multi-port AXI performance monitor (read-only tap on NumPorts req/rsp pairs).
// Inputs : clk_i, rst_ni (async, active-low), en_i (windowed counting enable),
//          clear_i (sync clear of everything), end_of_sim_i, req_i, rsp_i.
// Outputs: per-port r/w beats of the last window, window_cycles_o, window_valid_o
//          pulse, per-port ar/aw in-flight and peaks, done_o, per-port err_o.
// Holds the global FSM (IDLE/COUNT/DRAIN/DONE), the window counter and the drain check;
// per-port statistics live in floo_axi_perf_port.
module floo_axi_perf_monitor
    import floo_test_pkg::*;
#(
    parameter int unsigned NumPorts      = 16,
    parameter int unsigned WindowCycles  = 1000,
    parameter int unsigned CntWidth      = 32,
    parameter int unsigned InFlightWidth = 8,
    parameter type         axi_req_t     = perf_axi_req_t,
    parameter type         axi_rsp_t     = perf_axi_rsp_t
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    en_i,
    input  logic                                    clear_i,
    input  logic [NumPorts-1:0]                     end_of_sim_i,
    input  axi_req_t [NumPorts-1:0]                 req_i,
    input  axi_rsp_t [NumPorts-1:0]                 rsp_i,
    output logic [NumPorts-1:0][CntWidth-1:0]       r_beats_o,
    output logic [NumPorts-1:0][CntWidth-1:0]       w_beats_o,
    output logic [CntWidth-1:0]                     window_cycles_o,
    output logic                                    window_valid_o,
    output logic [NumPorts-1:0][InFlightWidth-1:0]  ar_in_flight_o,
    output logic [NumPorts-1:0][InFlightWidth-1:0]  aw_in_flight_o,
    output logic [NumPorts-1:0][InFlightWidth-1:0]  ar_peak_o,
    output logic [NumPorts-1:0][InFlightWidth-1:0]  aw_peak_o,
    output logic                                    done_o,
    output logic [NumPorts-1:0]                     err_o
);

    // The window counter is widened when WindowCycles does not fit in CntWidth;
    // window_cycles_o then reports the saturated length.
    localparam int unsigned WinLog = unsigned'($clog2(WindowCycles + 1));
    localparam int unsigned WinW   = (CntWidth > WinLog) ? CntWidth : WinLog;

    perf_mon_state_e     state_q, state_d;
    logic [WinW-1:0]     win_cnt_q, win_cnt_d, win_inc;
    logic [CntWidth-1:0] win_cyc_q, win_cyc_d;
    logic                win_vld_q, win_vld_d;
    logic                done_q, done_d;
    logic                snap, flush, counting, boundary, all_eos, all_idle;

    logic [NumPorts-1:0] ar_hs, r_hs, r_last_hs, aw_hs, w_hs, b_hs, port_idle;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        assign ar_hs[p]     = req_i[p].ar_valid & rsp_i[p].ar_ready;
        assign r_hs[p]      = rsp_i[p].r_valid  & req_i[p].r_ready;
        assign r_last_hs[p] = r_hs[p] & rsp_i[p].r.last;
        assign aw_hs[p]     = req_i[p].aw_valid & rsp_i[p].aw_ready;
        assign w_hs[p]      = req_i[p].w_valid  & rsp_i[p].w_ready;
        assign b_hs[p]      = rsp_i[p].b_valid  & req_i[p].b_ready;
        assign port_idle[p] = (ar_in_flight_o[p] == '0) && (aw_in_flight_o[p] == '0);

        floo_axi_perf_port #(
            .CntWidth      (CntWidth),
            .InFlightWidth (InFlightWidth)
        ) i_port (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .clear_i        (clear_i),
            .count_i        (counting),
            .snap_i         (snap),
            .flush_i        (flush),
            .ar_hs_i        (ar_hs[p]),
            .r_hs_i         (r_hs[p]),
            .r_last_hs_i    (r_last_hs[p]),
            .aw_hs_i        (aw_hs[p]),
            .w_hs_i         (w_hs[p]),
            .b_hs_i         (b_hs[p]),
            .r_beats_o      (r_beats_o[p]),
            .w_beats_o      (w_beats_o[p]),
            .ar_in_flight_o (ar_in_flight_o[p]),
            .aw_in_flight_o (aw_in_flight_o[p]),
            .ar_peak_o      (ar_peak_o[p]),
            .aw_peak_o      (aw_peak_o[p]),
            .err_o          (err_o[p])
        );
    end

    assign all_eos  = &end_of_sim_i;
    assign all_idle = &port_idle;
    assign counting = (state_q == COUNT);
    assign boundary = counting && (win_cnt_q == WinW'(WindowCycles - 1));
    assign win_inc  = win_cnt_q + WinW'(1);

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        win_cyc_d = win_cyc_q;
        win_vld_d = 1'b0;
        snap      = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = COUNT;
            end
            COUNT: begin
                // A drain request closes the partial window like a full one; when it
                // lands on the window boundary both collapse into one snapshot.
                snap = all_eos || boundary;
                if (all_eos) begin
                    state_d = DRAIN;
                end else if (!en_i) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end
                win_cnt_d = (snap || !en_i) ? '0 : win_inc;
            end
            DRAIN: begin
                if (all_idle) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (snap) begin
            win_vld_d = 1'b1;
            if ((WinW > CntWidth) && ((win_inc >> CntWidth) != '0)) win_cyc_d = '1;
            else                                                    win_cyc_d = win_inc[CntWidth-1:0];
        end
        if (clear_i) begin
            state_d   = IDLE;
            win_cnt_d = '0;
            win_cyc_d = '0;
            win_vld_d = 1'b0;
        end
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            win_cyc_q <= '0;
            win_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            win_cyc_q <= win_cyc_d;
            win_vld_q <= win_vld_d;
            done_q    <= done_d;
        end
    end

    assign window_cycles_o = win_cyc_q;
    assign window_valid_o  = win_vld_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_floo_axi_perf_monitor.sv
// Bench for floo_axi_perf_monitor: a 2-port instance (10-cycle window) for reset,
// windowing, in-flight, underflow and drain, and a 1-port instance with 4-bit counters
// and a 25-cycle window for saturation. Expected window snapshots are queued when the
// stimulus is driven and compared when window_valid_o pulses.
module tb_floo_axi_perf_monitor;
    import floo_test_pkg::*;

    localparam int NP  = 2;
    localparam int WC  = 10;
    localparam int CW  = 8;
    localparam int IFW = 4;
    localparam int WC2 = 25;
    localparam int CW2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic en = 1'b0;
    logic en2 = 1'b0;
    logic [NP-1:0] eos = '0;
    logic [0:0]    eos2 = '0;
    perf_axi_req_t [NP-1:0] req = '0;
    perf_axi_rsp_t [NP-1:0] rsp = '0;
    perf_axi_req_t [0:0]    req2 = '0;
    perf_axi_rsp_t [0:0]    rsp2 = '0;

    logic [NP-1:0][CW-1:0]  r_beats1, w_beats1;
    logic [CW-1:0]          wcyc1;
    logic                   wvld1, done1;
    logic [NP-1:0][IFW-1:0] arf1, awf1, arp1, awp1;
    logic [NP-1:0]          err1;

    logic [0:0][CW2-1:0]    r_beats2, w_beats2;
    logic [CW2-1:0]         wcyc2;
    logic                   wvld2, done2;
    logic [0:0][IFW-1:0]    arf2, awf2, arp2, awp2;
    logic [0:0]             err2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int r;
        int w;
        int cyc;
    } snap_t;
    snap_t sb1[$];
    snap_t sb2[$];

    always #5 clk = ~clk;

    floo_axi_perf_monitor #(
        .NumPorts(NP), .WindowCycles(WC), .CntWidth(CW), .InFlightWidth(IFW)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .end_of_sim_i(eos),
        .req_i(req), .rsp_i(rsp), .r_beats_o(r_beats1), .w_beats_o(w_beats1),
        .window_cycles_o(wcyc1), .window_valid_o(wvld1), .ar_in_flight_o(arf1),
        .aw_in_flight_o(awf1), .ar_peak_o(arp1), .aw_peak_o(awp1), .done_o(done1),
        .err_o(err1)
    );

    floo_axi_perf_monitor #(
        .NumPorts(1), .WindowCycles(WC2), .CntWidth(CW2), .InFlightWidth(IFW)
    ) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .clear_i(clear), .end_of_sim_i(eos2),
        .req_i(req2), .rsp_i(rsp2), .r_beats_o(r_beats2), .w_beats_o(w_beats2),
        .window_cycles_o(wcyc2), .window_valid_o(wvld2), .ar_in_flight_o(arf2),
        .aw_in_flight_o(awf2), .ar_peak_o(arp2), .aw_peak_o(awp2), .done_o(done2),
        .err_o(err2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon1
        snap_t e;
        if (rst_n && wvld1) begin
            if (sb1.size() == 0) begin
                check_eq("dut1_unexpected_pulse", 64'd1, 64'd0);
            end else begin
                e = sb1.pop_front();
                check_eq("dut1_r_beats0", 64'(r_beats1[0]), 64'(e.r));
                check_eq("dut1_w_beats0", 64'(w_beats1[0]), 64'(e.w));
                check_eq("dut1_window_cycles", 64'(wcyc1), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon2
        snap_t e;
        if (rst_n && wvld2) begin
            if (sb2.size() == 0) begin
                check_eq("dut2_unexpected_pulse", 64'd1, 64'd0);
            end else begin
                e = sb2.pop_front();
                check_eq("dut2_r_beats0", 64'(r_beats2[0]), 64'(e.r));
                check_eq("dut2_w_beats0", 64'(w_beats2[0]), 64'(e.w));
                check_eq("dut2_window_cycles", 64'(wcyc2), 64'(e.cyc));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset asserted while reads are being issued
        req[0].ar_valid = 1'b1; rsp[0].ar_ready = 1'b1;
        step(); step();
        check_eq("pre_reset_ar_in_flight", 64'(arf1[0]), 64'd2);
        rst_n = 1'b0;
        #1;
        check_eq("reset_ar_in_flight", 64'(arf1[0]), 64'd0);
        check_eq("reset_ar_peak", 64'(arp1[0]), 64'd0);
        check_eq("reset_done", 64'(done1), 64'd0);
        check_eq("reset_err", 64'(err1), 64'd0);
        check_eq("reset_window_valid", 64'(wvld1), 64'd0);
        check_eq("reset_window_cycles", 64'(wcyc1), 64'd0);
        step();
        check_eq("reset_held_ar_in_flight", 64'(arf1[0]), 64'd0);
        req[0].ar_valid = 1'b0; rsp[0].ar_ready = 1'b0;
        rst_n = 1'b1;
        step();

        // In-flight tracking on port 1
        req[1].ar_valid = 1'b1; rsp[1].ar_ready = 1'b1;
        step(); step(); step();
        check_eq("ar_in_flight_after_3ar", 64'(arf1[1]), 64'd3);
        check_eq("ar_peak_lags_one_cycle", 64'(arp1[1]), 64'd2);
        rsp[1].r_valid = 1'b1; req[1].r_ready = 1'b1; rsp[1].r.last = 1'b1;
        step();
        check_eq("ar_in_flight_inc_dec", 64'(arf1[1]), 64'd3);
        check_eq("ar_peak_3", 64'(arp1[1]), 64'd3);
        req[1].ar_valid = 1'b0; rsp[1].ar_ready = 1'b0;
        step(); step(); step();
        rsp[1].r_valid = 1'b0; req[1].r_ready = 1'b0; rsp[1].r.last = 1'b0;
        check_eq("ar_in_flight_drained", 64'(arf1[1]), 64'd0);
        check_eq("ar_peak_kept", 64'(arp1[1]), 64'd3);
        check_eq("no_err_after_reads", 64'(err1), 64'd0);

        // Underflow: B with nothing outstanding on port 0
        rsp[0].b_valid = 1'b1; req[0].b_ready = 1'b1;
        step();
        rsp[0].b_valid = 1'b0; req[0].b_ready = 1'b0;
        check_eq("underflow_aw_in_flight", 64'(awf1[0]), 64'd0);
        check_eq("underflow_err", 64'(err1), 64'd1);
        step(); step();
        check_eq("underflow_err_sticky", 64'(err1), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clear_err", 64'(err1), 64'd0);
        check_eq("clear_ar_peak", 64'(arp1[1]), 64'd0);

        // Windowed R beat counting: 25 beats, two full windows of 10
        en = 1'b1;
        step();
        sb1.push_back('{r: 10, w: 0, cyc: WC});
        sb1.push_back('{r: 10, w: 0, cyc: WC});
        rsp[0].r_valid = 1'b1; req[0].r_ready = 1'b1;
        repeat (25) step();
        rsp[0].r_valid = 1'b0; req[0].r_ready = 1'b0;
        en = 1'b0;
        repeat (4) step();
        check_eq("window_pulses_seen", 64'(sb1.size()), 64'd0);

        // Drain: two writes outstanding, end of sim at window cycle 4
        req[0].aw_valid = 1'b1; rsp[0].aw_ready = 1'b1;
        step(); step();
        req[0].aw_valid = 1'b0; rsp[0].aw_ready = 1'b0;
        check_eq("aw_in_flight_2", 64'(awf1[0]), 64'd2);
        en = 1'b1;
        step();
        // r=0 also shows the earlier partial window was discarded
        sb1.push_back('{r: 0, w: 5, cyc: 5});
        req[0].w_valid = 1'b1; rsp[0].w_ready = 1'b1;
        repeat (4) step();
        eos = '1;
        step();
        req[0].w_valid = 1'b0; rsp[0].w_ready = 1'b0;
        eos = '0;
        en = 1'b0;
        repeat (3) step();
        check_eq("done_wait_for_b", 64'(done1), 64'd0);
        rsp[0].b_valid = 1'b1; req[0].b_ready = 1'b1;
        step(); step();
        rsp[0].b_valid = 1'b0; req[0].b_ready = 1'b0;
        check_eq("aw_in_flight_0", 64'(awf1[0]), 64'd0);
        check_eq("done_not_yet", 64'(done1), 64'd0);
        step();
        check_eq("done_rises", 64'(done1), 64'd1);
        step(); step();
        check_eq("done_sticky", 64'(done1), 64'd1);
        check_eq("drain_no_err", 64'(err1), 64'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clear_done", 64'(done1), 64'd0);
        step(); step();
        check_eq("idle_after_clear", 64'(done1), 64'd0);

        // Saturation of a 4-bit beat counter: 20 W beats in a 25-cycle window
        en2 = 1'b1;
        step();
        sb2.push_back('{r: 0, w: 15, cyc: 15});
        req2[0].w_valid = 1'b1; rsp2[0].w_ready = 1'b1;
        repeat (20) step();
        req2[0].w_valid = 1'b0; rsp2[0].w_ready = 1'b0;
        repeat (5) step();
        en2 = 1'b0;
        repeat (3) step();
        check_eq("sat_no_err", 64'(err2), 64'd0);

        check_eq("sb1_drained", 64'(sb1.size()), 64'd0);
        check_eq("sb2_drained", 64'(sb2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
